// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit: applies AND/OR/XOR/NOR to latched operands
// one LANE-bit slice per cycle, with a valid/ready handshake on both sides.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             zero,
  output logic             ones
);

  localparam int N  = WIDTH / LANE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] x_lat;
  logic [WIDTH-1:0] y_lat;
  logic [1:0]       op_lat;
  logic [WIDTH-1:0] a_next;
  logic             accept;
  logic             last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (k == KW'(N - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Each lane computes its slice; only the lane selected by k is written,
  // all other bits of a keep their previous value.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : lane_g
      logic [LANE-1:0] lane_x;
      logic [LANE-1:0] lane_y;
      logic [LANE-1:0] lane_res;

      assign lane_x = x_lat[gi*LANE +: LANE];
      assign lane_y = y_lat[gi*LANE +: LANE];

      always_comb begin
        lane_res = '0;
        case (op_lat)
          2'b00:   lane_res = lane_x & lane_y;
          2'b01:   lane_res = lane_x | lane_y;
          2'b10:   lane_res = lane_x ^ lane_y;
          default: lane_res = ~(lane_x | lane_y);
        endcase
      end

      assign a_next[gi*LANE +: LANE] =
        ((state == BUSY) && (k == KW'(gi))) ? lane_res : a[gi*LANE +: LANE];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k      <= '0;
      x_lat  <= '0;
      y_lat  <= '0;
      op_lat <= 2'b00;
      a      <= '0;
      zero   <= 1'b0;
      ones   <= 1'b0;
    end else begin
      if (accept) begin
        x_lat  <= x;
        y_lat  <= y;
        op_lat <= op;
        k      <= '0;
      end
      if (state == BUSY) begin
        a <= a_next;
        if (last) begin
          // Flags come from the fully assembled word, so they match a in DONE.
          k    <= '0;
          zero <= (a_next == '0);
          ones <= &a_next;
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: directed and randomized operations
// on a 32/8 instance and a single-lane 16/16 instance against a word-level model.
module tb_logic_unit_seq;

  localparam int W  = 32;
  localparam int L  = 8;
  localparam int NL = W / L;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a;
  logic          zero;
  logic          ones;

  logic          c2_in_valid = 1'b0;
  logic          c2_in_ready;
  logic [1:0]    c2_op = 2'b00;
  logic [15:0]   c2_x = '0;
  logic [15:0]   c2_y = '0;
  logic          c2_out_valid;
  logic          c2_out_ready = 1'b0;
  logic [15:0]   c2_a;
  logic          c2_zero;
  logic          c2_ones;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_a = '0;

  always #5 clock = ~clock;

  logic_unit_seq #(.WIDTH(W), .LANE(L)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .zero(zero), .ones(ones)
  );

  logic_unit_seq #(.WIDTH(16), .LANE(16)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
    .op(c2_op), .x(c2_x), .y(c2_y), .out_valid(c2_out_valid), .out_ready(c2_out_ready),
    .a(c2_a), .zero(c2_zero), .ones(c2_ones)
  );

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] p, input logic [W-1:0] q);
    case (o)
      2'b00:   return p & q;
      2'b01:   return p | q;
      2'b10:   return p ^ q;
      default: return ~(p | q);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] px, input logic [W-1:0] py, input int hold);
    logic [W-1:0] exp_a;
    logic [63:0]  mask;
    int lat;
    exp_a = ref_op(o, px, py);
    @(negedge clock);
    check("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; op = o; x = px; y = py; out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      #1;
      if (out_valid) break;
      mask = (64'd1 << (lat * L)) - 64'd1;
      check("partial_a", a, (exp_a & mask[W-1:0]) | (prev_a & ~mask[W-1:0]));
      x = $urandom; y = $urandom; op = 2'($urandom); in_valid = 1'($urandom);
      out_ready = 1'($urandom);
    end
    check("latency", lat, NL);
    check("result_a", a, exp_a);
    check("zero", zero, exp_a == '0);
    check("ones", ones, exp_a == '1);
    check("done_in_ready", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; in_valid = 1'b1; x = ~x; y = ~y; op = op + 2'd1;
      @(posedge clock);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_a", a, exp_a);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clock);
    #1;
    check("release_idle", in_ready, 1'b1);
    check("release_valid", out_valid, 1'b0);
    out_ready = 1'b0; in_valid = 1'b0;
    prev_a = exp_a;
    $display("txn op=%0d x=%08h y=%08h a=%08h lat=%0d hold=%0d", o, px, py, a, lat, hold);
  endtask

  initial begin
    logic [15:0] e16;
    #1;
    check("rst_a", a, 0);
    check("rst_zero", zero, 0);
    check("rst_ones", ones, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(2'b01, 32'h0000FFFF, 32'h12340000, 0);
    run_op(2'b11, 32'h0, 32'h0, 0);
    run_op(2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 0);
    run_op(2'b10, 32'hAAAAAAAA, 32'hFFFFFFFF, 5);

    // Reset in BUSY at k=2 aborts the operation.
    @(negedge clock);
    in_valid = 1'b1; op = 2'b01; x = 32'hDEADBEEF; y = 32'h0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("abort_a", a, 0);
    check("abort_zero", zero, 0);
    check("abort_ones", ones, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    prev_a = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1 check("abort_no_valid", out_valid, 0);
    end
    run_op(2'b00, 32'h12345678, 32'hFF00FF00, 1);

    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // Single-lane instance: BUSY lasts one cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      c2_in_valid = 1'b1;
      c2_op = (i == 0) ? 2'b00 : 2'($urandom);
      c2_x  = (i == 0) ? 16'hFF00 : 16'($urandom);
      c2_y  = (i == 0) ? 16'h0FF0 : 16'($urandom);
      e16 = ref_op(c2_op, {16'h0, c2_x}, {16'h0, c2_y}) & 32'h0000FFFF;
      @(posedge clock);
      #1 c2_in_valid = 1'b0;
      check("c2_busy_valid", c2_out_valid, 0);
      @(posedge clock);
      #1;
      check("c2_valid", c2_out_valid, 1);
      check("c2_a", c2_a, e16);
      check("c2_zero", c2_zero, e16 == 16'h0);
      check("c2_ones", c2_ones, e16 == 16'hFFFF);
      c2_out_ready = 1'b1;
      @(posedge clock);
      #1 c2_out_ready = 1'b0;
      check("c2_idle", c2_in_ready, 1);
      $display("txn16 op=%0d x=%04h y=%04h a=%04h", c2_op, c2_x, c2_y, c2_a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter LANE, default 8, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of LANE, and N = WIDTH/LANE.
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock, with all state updating on the rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning the operands and op are presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the unit can accept a new operation.
REQ-007 The module SHALL have port op, input, 2 bits, the operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 The module SHALL have port x, input, WIDTH bits, operand x.
REQ-009 The module SHALL have port y, input, WIDTH bits, operand y.
REQ-010 The module SHALL have port out_valid, output, 1 bit, meaning the result is available.
REQ-011 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The module SHALL have port a, output, WIDTH bits, the result.
REQ-013 The module SHALL have port zero, output, 1 bit, asserted when a equals 0.
REQ-014 The module SHALL have port ones, output, 1 bit, asserted when every bit of a is 1.

Function
REQ-015 The module SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both SHALL be registered-state decodes.
REQ-017 In IDLE, in_valid=1 SHALL cause an accept at the clock edge: x, y and op are latched, the lane counter is set to 0, and the FSM moves to BUSY.
REQ-018 In BUSY, each cycle SHALL write result bits [k*LANE+LANE-1 : k*LANE] = op(x_lat, y_lat) for that slice, where k is the lane counter, and then increment k.
REQ-019 When k = N-1 in BUSY, the FSM SHALL write the final slice, update zero and ones from the complete result, clear k to 0 (wrap), and move to DONE.
REQ-020 Latency: out_valid SHALL rise exactly N rising edges after the accept edge (4 for defaults); with LANE = WIDTH, BUSY SHALL last exactly one cycle.
REQ-021 In DONE, out_valid, a, zero and ones SHALL remain stable until out_ready=1 is sampled; the FSM SHALL then return to IDLE.
REQ-022 A new accept SHALL NOT occur in the cycle the FSM leaves DONE; the minimum spacing is N+2 cycles between accepts.
REQ-023 Changes to x, y, op and in_valid while in BUSY or DONE SHALL have no effect on the operation in flight.
REQ-024 In BUSY, the bits of a that are not yet written SHALL hold their previous values; a is only defined as a full result while out_valid=1.
REQ-025 zero and ones SHALL be registered flags, consistent with a whenever out_valid=1.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 NOR SHALL be computed as the bitwise inverse of OR across all WIDTH bits; no op value is illegal.

Reset
REQ-028 reset_n=0 SHALL force, immediately and asynchronously: FSM to IDLE, k=0, a=0, zero=0, ones=0, out_valid=0, in_ready=1.
REQ-029 Reset asserted during BUSY or DONE SHALL abort the operation, discard the partial result, and produce no out_valid after release.
REQ-030 After reset_n deasserts, the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-031 Defaults, op=01, x=0x0000FFFF, y=0x12340000, out_ready=1 -> out_valid is asserted 4 edges after accept, a=0x1234FFFF, zero=0, ones=0.
REQ-032 op=11 (NOR), x=0, y=0 -> a=0xFFFFFFFF, ones=1; then op=00, x=0xF0F0F0F0, y=0x0F0F0F0F -> a=0, zero=1.
REQ-033 op=10, x=0xAAAAAAAA, y=0xFFFFFFFF, out_ready held at 0 for 5 cycles -> a=0x55555555 stays stable with out_valid=1, in_ready=0, and x/y toggled without effect; release -> IDLE.
REQ-034 reset_n pulsed low at BUSY k=2 -> outputs zeroed at once, no out_valid afterwards, and the next operation completes correctly.
REQ-035 WIDTH=16, LANE=16, op=00, x=0xFF00, y=0x0FF0 -> out_valid 1 edge after accept, a=0x0F00.
